// File: rtl/vde_scanout_if.sv
// Pixel stream from the VDE producer into the scanout block.
// The producer drives valid/data and the scanout block drives ready.
`timescale 1ns/1ps
interface vde_scanout_if;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic        pixel_ready;

    modport master (output pixel_valid, output pixel_data, input pixel_ready);
    modport slave  (input pixel_valid, input pixel_data, output pixel_ready);
endinterface

// File: rtl/vde_scanout.sv
// Raster timing generator and prefetch FIFO for the VDE pixel stream.
// Toggles frame_idx_o at the start of vertical blanking so the producer restarts its frame.
`timescale 1ns/1ps
module vde_scanout #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_FP           = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BP           = 48,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_FP           = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BP           = 33,
    parameter bit          HSYNC_POL      = 1'b0,
    parameter bit          VSYNC_POL      = 1'b0,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned FLUSH_CYCLES   = 4,
    parameter logic [23:0] UNDERRUN_COLOR = 24'hFF00FF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    vde_scanout_if.slave  pix,
    output logic          frame_idx_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [23:0]   rgb_o,
    output logic          underrun_o
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned NPIX    = H_ACTIVE * V_ACTIVE;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned CW      = $clog2(NPIX + 1);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned FW      = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_TOG    = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] NPIX_C   = CW'(NPIX);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [FW-1:0] FLUSH_C  = FW'(FLUSH_CYCLES);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          frame_q, frame_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [CW-1:0] fetch_q, fetch_d;
    logic [CW-1:0] debt_q, debt_d, debt_tmp;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          de_q, de_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d, vs_q, vs_d;
    logic          und_q, und_d;
    logic [23:0]   fifo_mem [FIFO_DEPTH];

    logic active, toggle, hshk, push, pop, starve;

    always_comb begin
        active   = (h_q < H_ACT) && (v_q < V_ACT);
        toggle   = (h_q == H_LAST) && (v_q == V_TOG);
        hshk     = pix.pixel_valid && ready_q;
        push     = hshk && !toggle && (debt_q == '0);
        pop      = active && (cnt_q != '0);
        starve   = active && (cnt_q == '0);

        h_d      = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d      = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end

        de_d     = active;
        rgb_d    = '0;
        if (pop) begin
            rgb_d = fifo_mem[rd_q];
        end else if (starve) begin
            rgb_d = UNDERRUN_COLOR;
        end
        hs_d     = (h_q >= HS_FIRST && h_q <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
        vs_d     = (v_q >= VS_FIRST && v_q <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;

        frame_d  = frame_q;
        flush_d  = (flush_q != '0) ? flush_q - 1'b1 : '0;
        fetch_d  = hshk ? fetch_q + 1'b1 : fetch_q;
        // A discarded pixel repays debt taken by an earlier starved position.
        debt_tmp = (hshk && debt_q != '0) ? debt_q - 1'b1 : debt_q;
        debt_d   = (starve && debt_tmp != '1) ? debt_tmp + 1'b1 : debt_tmp;
        und_d    = und_q | starve;
        wr_d     = wr_q + AW'(push);
        rd_d     = rd_q + AW'(pop);
        cnt_d    = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);

        if (toggle) begin
            frame_d = ~frame_q;
            flush_d = FLUSH_C;
            fetch_d = '0;
            debt_d  = '0;
            und_d   = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
        end

        // Evaluated on next-state values so an accepted write can never overflow.
        ready_d  = (cnt_d < DEPTH_C) && (flush_d == '0) && (fetch_d < NPIX_C);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q     <= '0;
            v_q     <= V_ACT;
            frame_q <= 1'b0;
            flush_q <= FLUSH_C;
            fetch_q <= '0;
            debt_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            und_q   <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            flush_q <= flush_d;
            fetch_q <= fetch_d;
            debt_q  <= debt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            und_q   <= und_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_q] <= pix.pixel_data;
        end
    end

    assign pix.pixel_ready = ready_q;
    assign frame_idx_o     = frame_q;
    assign hsync_o         = hs_q;
    assign vsync_o         = vs_q;
    assign de_o            = de_q;
    assign rgb_o           = rgb_q;
    assign underrun_o      = und_q;
endmodule

// File: tb/tb_vde_scanout.sv
// Randomized bench for vde_scanout against a queue-based raster/FIFO reference model.
// Two instances share the stimulus: one with active-low syncs, one with active-high syncs.
`timescale 1ns/1ps
module tb_vde_scanout;
    localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int NPIX = HA * VA;
    localparam int DEPTH = 4, FLUSH = 4;
    localparam logic [23:0] UCOL = 24'hFF00FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        tb_valid = 1'b0;
    logic [23:0] tb_data  = '0;

    vde_scanout_if if0 ();
    vde_scanout_if if1 ();
    assign if0.pixel_valid = tb_valid;
    assign if0.pixel_data  = tb_data;
    assign if1.pixel_valid = tb_valid;
    assign if1.pixel_data  = tb_data;

    logic frame0, hs0, vs0, de0, und0;
    logic frame1, hs1, vs1, de1, und1;
    logic [23:0] rgb0, rgb1;

    vde_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .UNDERRUN_COLOR(UCOL)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .pix(if0),
        .frame_idx_o(frame0), .hsync_o(hs0), .vsync_o(vs0),
        .de_o(de0), .rgb_o(rgb0), .underrun_o(und0)
    );

    vde_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .UNDERRUN_COLOR(UCOL)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .pix(if1),
        .frame_idx_o(frame1), .hsync_o(hs1), .vsync_o(vs1),
        .de_o(de1), .rgb_o(rgb1), .underrun_o(und1)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raster position as a linear index, FIFO as a queue.
    int          m_pos;
    bit          m_frame, m_und, m_ready;
    int          m_flush, m_fetched, m_debt;
    logic [23:0] m_q[$];
    bit          e_de, e_hs_on, e_vs_on;
    logic [23:0] e_rgb;

    // Producer state
    int          pix;
    int          frames_seen;
    int          stall_left;
    bit          prev_frame;
    bit          hs_pend;
    logic [7:0]  salt;
    int          mode_tab [5] = '{0, 1, 2, 3, 0};

    task automatic model_reset();
        m_pos = VA * HT;
        m_frame = 1'b0;
        m_und = 1'b0;
        m_ready = 1'b0;
        m_flush = FLUSH;
        m_fetched = 0;
        m_debt = 0;
        m_q.delete();
        e_de = 1'b0;
        e_rgb = '0;
        e_hs_on = 1'b0;
        e_vs_on = 1'b0;
        pix = 0;
        frames_seen = 0;
        stall_left = 8;
        prev_frame = 1'b0;
        hs_pend = 1'b0;
        salt = 8'h00;
    endtask

    task automatic model_step(input bit v, input logic [23:0] d);
        int  h, ln;
        bit  act, tog, shake, starve;
        h = m_pos % HT;
        ln = m_pos / HT;
        act = (h < HA) && (ln < VA);
        tog = (h == HT - 1) && (ln == VA - 1);
        shake = v && m_ready;
        e_de = act;
        e_hs_on = (h >= HA + HFP) && (h < HA + HFP + HSW);
        e_vs_on = (ln >= VA + VFP) && (ln < VA + VFP + VSW);
        starve = 1'b0;
        e_rgb = '0;
        if (act) begin
            if (m_q.size() > 0) e_rgb = m_q.pop_front();
            else begin
                e_rgb = UCOL;
                starve = 1'b1;
            end
        end
        if (tog) begin
            m_frame = !m_frame;
            m_q.delete();
            m_fetched = 0;
            m_debt = 0;
            m_und = 1'b0;
            m_flush = FLUSH;
        end else begin
            if (m_flush > 0) m_flush--;
            if (shake) begin
                m_fetched++;
                if (m_debt > 0) m_debt--;
                else m_q.push_back(d);
            end
            if (starve) begin
                m_und = 1'b1;
                if (m_debt < 63) m_debt++;
            end
        end
        m_ready = (m_q.size() < DEPTH) && (m_flush == 0) && (m_fetched < NPIX);
        m_pos = (m_pos + 1) % (HT * VT);
    endtask

    // Decide this cycle's producer output and advance the model across the next edge.
    task automatic drive_step();
        bit          v;
        logic [23:0] d;
        int          mode;
        if (hs_pend) pix++;
        if (m_frame != prev_frame) begin
            pix = 0;
            frames_seen++;
            stall_left = 8;
            salt = 8'($urandom);
        end
        prev_frame = m_frame;
        mode = mode_tab[frames_seen % 5];
        case (mode)
            1: begin
                if (pix == 12 && stall_left > 0) begin
                    v = 1'b0;
                    stall_left--;
                end else v = 1'b1;
            end
            2: v = ($urandom_range(0, 3) != 0);
            3: v = (pix < 20);
            default: v = 1'b1;
        endcase
        d = (frames_seen == 0) ? 24'(pix) : {salt, 16'(pix)};
        tb_valid = v;
        tb_data = d;
        hs_pend = v && m_ready;
        model_step(v, d);
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("rgb0", rgb0, e_rgb);
        chk("rgb1", rgb1, e_rgb);
        chk("de0", de0, e_de);
        chk("de1", de1, e_de);
        chk("hsync0", hs0, !e_hs_on);
        chk("hsync1", hs1, e_hs_on);
        chk("vsync0", vs0, !e_vs_on);
        chk("vsync1", vs1, e_vs_on);
        chk("frame0", frame0, m_frame);
        chk("frame1", frame1, m_frame);
        chk("underrun", und0, m_und);
        chk("ready", if0.pixel_ready, m_ready);
        drive_step();
    endtask

    task automatic chk_reset();
        chk("rst_de", de0, 0);
        chk("rst_rgb", rgb0, 0);
        chk("rst_und", und0, 0);
        chk("rst_frame", frame0, 0);
        chk("rst_ready", if0.pixel_ready, 0);
        chk("rst_hs0", hs0, 1);
        chk("rst_vs0", vs0, 1);
        chk("rst_hs1", hs1, 0);
        chk("rst_vs1", vs1, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        drive_step();
        repeat (42 + 5 * HT * VT) cycle();

        // Run to the middle of an active line, then hit reset between edges.
        for (int i = 0; i < HT * VT && m_pos != HT + 3; i++) cycle();
        @(posedge clk);
        #2 rst = 1'b1;
        tb_valid = 1'b0;
        #1 chk_reset();
        @(negedge clk);
        @(negedge clk);
        chk_reset();
        model_reset();
        rst = 1'b0;
        drive_step();
        repeat (42 + HT * VT + 10) cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
